// File: rtl/pipe_pkg.sv
// Shared pipeline package: datapath defaults, ALU encodings, condition codes,
// and the packed control word carried from decode through execute and memory.
package pipe_pkg;

    localparam int DW_DEF = 32;
    localparam int RW_DEF = 4;

    // ALU operation encodings
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // Condition field value meaning "always"
    localparam logic [3:0] COND_AL = 4'b1110;

    // Control word passed between pipeline stages
    typedef struct packed {
        logic       valid;
        logic       pcs;
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       branch;
        logic       alu_src;
        logic [1:0] alu_control;
        logic [1:0] flag_write;
        logic [3:0] cond;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // Inert bubble: nothing valid, no side effects, condition "always"
    localparam ctrl_t CTRL_BUBBLE = '{
        valid:       1'b0,
        pcs:         1'b0,
        reg_write:   1'b0,
        mem_to_reg:  1'b0,
        mem_write:   1'b0,
        branch:      1'b0,
        alu_src:     1'b0,
        alu_control: 2'b00,
        flag_write:  2'b00,
        cond:        COND_AL
    };

    // Strip every architecturally visible side effect from an invalid slot,
    // so a squashed instruction can never write registers, memory or flags.
    function automatic ctrl_t gate_side_effects(input ctrl_t c);
        ctrl_t g;
        g = c;
        if (c.valid == 1'b0) begin
            g.pcs        = 1'b0;
            g.reg_write  = 1'b0;
            g.mem_write  = 1'b0;
            g.branch     = 1'b0;
            g.flag_write = 2'b00;
        end else begin
            g = c;
        end
        return g;
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        logic [31:0] r;
        if (v == 32'hFFFF_FFFF) begin
            r = v;
        end else begin
            r = v + 32'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/flopenrc.sv
// Flop with enable, synchronous reset to zero, and synchronous clear to a
// parameterised value. Clear takes priority over enable.
module flopenrc #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // State update: reset > clear > enable load > hold
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (clear) begin
            q <= CLR_VAL;
        end else if (en) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/id_ex_pipe.sv
// Decode-to-execute pipeline register. Holds the control word (with side
// effects already gated by the valid bit) and the operand/tag word.
// Stall holds, flush inserts an inert bubble (condition AL, nothing valid).
// Optional feature macro: ID_EX_PERF_EN adds saturating stall/flush counters.
module id_ex_pipe
    import pipe_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          StallE,
    input  logic          FlushE,
    input  logic          ValidD,
    input  logic          PCSD,
    input  logic          RegWriteD,
    input  logic          MemtoRegD,
    input  logic          MemWriteD,
    input  logic          BranchD,
    input  logic          ALUSrcD,
    input  logic [1:0]    ALUControlD,
    input  logic [1:0]    FlagWriteD,
    input  logic [3:0]    CondD,
    input  logic [DW-1:0] RD1D,
    input  logic [DW-1:0] RD2D,
    input  logic [DW-1:0] ExtImmD,
    input  logic [RW-1:0] RA1D,
    input  logic [RW-1:0] RA2D,
    input  logic [RW-1:0] WA3D,
    output logic          ValidE,
    output logic          PCSE,
    output logic          RegWriteE,
    output logic          MemtoRegE,
    output logic          MemWriteE,
    output logic          BranchE,
    output logic          ALUSrcE,
    output logic [1:0]    ALUControlE,
    output logic [1:0]    FlagWriteE,
    output logic [3:0]    CondE,
    output logic [DW-1:0] RD1E,
    output logic [DW-1:0] RD2E,
    output logic [DW-1:0] ExtImmE,
    output logic [RW-1:0] RA1E,
    output logic [RW-1:0] RA2E,
    output logic [RW-1:0] WA3E
`ifdef ID_EX_PERF_EN
    ,
    output logic [31:0]   StallCountE,
    output logic [31:0]   FlushCountE
`endif
);

    localparam int DATA_W = 3 * DW + 3 * RW;

    ctrl_t             ctrl_raw_s;
    ctrl_t             ctrl_d_s;
    ctrl_t             ctrl_q_s;
    logic [DATA_W-1:0] data_d_s;
    logic [DATA_W-1:0] data_q_s;
    logic              load_en_s;

    // Pack decode control bits and gate side effects before they are stored
    always_comb begin
        ctrl_raw_s             = CTRL_BUBBLE;
        ctrl_raw_s.valid       = ValidD;
        ctrl_raw_s.pcs         = PCSD;
        ctrl_raw_s.reg_write   = RegWriteD;
        ctrl_raw_s.mem_to_reg  = MemtoRegD;
        ctrl_raw_s.mem_write   = MemWriteD;
        ctrl_raw_s.branch      = BranchD;
        ctrl_raw_s.alu_src     = ALUSrcD;
        ctrl_raw_s.alu_control = ALUControlD;
        ctrl_raw_s.flag_write  = FlagWriteD;
        ctrl_raw_s.cond        = CondD;
        ctrl_d_s               = gate_side_effects(ctrl_raw_s);
    end

    // Operands and tags load unconditionally of the valid bit; forwarding
    // comparisons on a dead slot are harmless.
    assign data_d_s  = {RD1D, RD2D, ExtImmD, RA1D, RA2D, WA3D};
    assign load_en_s = ~StallE;

    flopenrc #(
        .WIDTH   (CTRL_W),
        .CLR_VAL (CTRL_BUBBLE)
    ) u_ctrl_reg (
        .clk   (clk),
        .reset (reset),
        .en    (load_en_s),
        .clear (FlushE),
        .d     (ctrl_d_s),
        .q     (ctrl_q_s)
    );

    flopenrc #(
        .WIDTH   (DATA_W),
        .CLR_VAL ({DATA_W{1'b0}})
    ) u_data_reg (
        .clk   (clk),
        .reset (reset),
        .en    (load_en_s),
        .clear (FlushE),
        .d     (data_d_s),
        .q     (data_q_s)
    );

    assign ValidE      = ctrl_q_s.valid;
    assign PCSE        = ctrl_q_s.pcs;
    assign RegWriteE   = ctrl_q_s.reg_write;
    assign MemtoRegE   = ctrl_q_s.mem_to_reg;
    assign MemWriteE   = ctrl_q_s.mem_write;
    assign BranchE     = ctrl_q_s.branch;
    assign ALUSrcE     = ctrl_q_s.alu_src;
    assign ALUControlE = ctrl_q_s.alu_control;
    assign FlagWriteE  = ctrl_q_s.flag_write;
    assign CondE       = ctrl_q_s.cond;

    assign {RD1E, RD2E, ExtImmE, RA1E, RA2E, WA3E} = data_q_s;

`ifdef ID_EX_PERF_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] flush_cnt_r;

    // Count cycles a valid instruction is held by a stall (flush wins)
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= 32'd0;
        end else if (StallE && !FlushE && ctrl_q_s.valid) begin
            stall_cnt_r <= sat_inc(stall_cnt_r);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    // Count valid instructions squashed by a flush
    always_ff @(posedge clk) begin
        if (reset) begin
            flush_cnt_r <= 32'd0;
        end else if (FlushE && ctrl_q_s.valid) begin
            flush_cnt_r <= sat_inc(flush_cnt_r);
        end else begin
            flush_cnt_r <= flush_cnt_r;
        end
    end

    assign StallCountE = stall_cnt_r;
    assign FlushCountE = flush_cnt_r;
`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
// Scoreboard bench for id_ex_pipe: each directed vector pushes its
// hand-computed expected E-stage word; a monitor pops and compares each cycle.
// Build with ID_EX_PERF_EN to also exercise the perf counters.
module tb_id_ex_pipe;

    typedef struct packed {
        logic        valid;
        logic        pcs;
        logic        rw;
        logic        m2r;
        logic        mw;
        logic        br;
        logic        as;
        logic [1:0]  alc;
        logic [1:0]  fw;
        logic [3:0]  cond;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [3:0]  ra1;
        logic [3:0]  ra2;
        logic [3:0]  wa3;
    } word_t;

    typedef struct {
        string name;
        word_t exp;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset, StallE, FlushE;
    logic        ValidD, PCSD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD;
    logic [1:0]  ALUControlD, FlagWriteD;
    logic [3:0]  CondD;
    logic [31:0] RD1D, RD2D, ExtImmD;
    logic [3:0]  RA1D, RA2D, WA3D;
    logic        ValidE, PCSE, RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE;
    logic [1:0]  ALUControlE, FlagWriteE;
    logic [3:0]  CondE;
    logic [31:0] RD1E, RD2E, ExtImmE;
    logic [3:0]  RA1E, RA2E, WA3E;
`ifdef ID_EX_PERF_EN
    logic [31:0] StallCountE, FlushCountE;
`endif

    sb_t   sbq[$];
    int    n_cmp  = 0;
    int    n_fail = 0;
    word_t out_w;

    always #5 clk = ~clk;

    id_ex_pipe dut (
        .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE),
        .ValidD(ValidD), .PCSD(PCSD), .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD),
        .MemWriteD(MemWriteD), .BranchD(BranchD), .ALUSrcD(ALUSrcD),
        .ALUControlD(ALUControlD), .FlagWriteD(FlagWriteD), .CondD(CondD),
        .RD1D(RD1D), .RD2D(RD2D), .ExtImmD(ExtImmD),
        .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
        .ValidE(ValidE), .PCSE(PCSE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
        .MemWriteE(MemWriteE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
        .ALUControlE(ALUControlE), .FlagWriteE(FlagWriteE), .CondE(CondE),
        .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE),
        .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E)
`ifdef ID_EX_PERF_EN
        , .StallCountE(StallCountE), .FlushCountE(FlushCountE)
`endif
    );

    // Gather DUT outputs into one comparable word
    always_comb begin
        out_w = {ValidE, PCSE, RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE,
                 ALUControlE, FlagWriteE, CondE, RD1E, RD2E, ExtImmE, RA1E, RA2E, WA3E};
    end

    function automatic word_t mkw(
        input logic v, input logic pcs, input logic rw, input logic m2r,
        input logic mw, input logic br, input logic as,
        input logic [1:0] alc, input logic [1:0] fw, input logic [3:0] cond,
        input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
        input logic [3:0] ra1, input logic [3:0] ra2, input logic [3:0] wa3);
        word_t w;
        w = {v, pcs, rw, m2r, mw, br, as, alc, fw, cond, rd1, rd2, imm, ra1, ra2, wa3};
        return w;
    endfunction

    // Drive one cycle of stimulus at the falling edge and queue its expectation
    task automatic step(input string name, input logic rst, input logic st,
                        input logic fl, input word_t d, input word_t exp);
        sb_t e;
        @(negedge clk);
        reset = rst; StallE = st; FlushE = fl;
        {ValidD, PCSD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD,
         ALUControlD, FlagWriteD, CondD, RD1D, RD2D, ExtImmD, RA1D, RA2D, WA3D} = d;
        e.name = name;
        e.exp  = exp;
        sbq.push_back(e);
    endtask

    // Monitor: one registered result per rising edge, checked 1 time unit later
    initial begin
        sb_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                n_cmp++;
                if (out_w !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", e.name, out_w, e.exp);
                end
            end
        end
    end

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    initial begin
        word_t all1, zero, bub, v3, v3b, vfl, vinv, einv, v14;
        int    wait_cnt;
        all1 = '1;
        zero = '0;
        bub  = mkw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'b1110,
                   32'd0, 32'd0, 32'd0, 4'd0, 4'd0, 4'd0);
        v3   = mkw(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0000,
                   32'h1234_5678, 32'd0, 32'd0, 4'd0, 4'd0, 4'd7);
        v3b  = mkw(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0000,
                   32'hDEAD_BEEF, 32'd0, 32'd0, 4'd0, 4'd0, 4'd7);
        vfl  = mkw(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b11, 4'b0000,
                   32'h0000_AAAA, 32'd0, 32'd0, 4'd5, 4'd0, 4'd0);
        vinv = mkw(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 2'b10, 4'b0101,
                   32'd0, 32'h0000_0055, 32'd0, 4'd3, 4'd0, 4'd2);
        einv = mkw(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 4'b0101,
                   32'd0, 32'h0000_0055, 32'd0, 4'd3, 4'd0, 4'd2);
        v14  = mkw(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b01, 4'b1010,
                   32'hCAFE_0001, 32'h0BAD_F00D, 32'h0000_0FFC, 4'd1, 4'd9, 4'd14);

        reset = 1'b1; StallE = 1'b0; FlushE = 1'b0;
        {ValidD, PCSD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD,
         ALUControlD, FlagWriteD, CondD, RD1D, RD2D, ExtImmD, RA1D, RA2D, WA3D} = all1;

        step("reset_1",        1'b1, 1'b0, 1'b0, all1, zero);
        step("reset_2",        1'b1, 1'b0, 1'b0, all1, zero);
        step("normal_load",    1'b0, 1'b0, 1'b0, v3,   v3);
        for (int i = 0; i < 3; i++) begin
            step("stall_hold",  1'b0, 1'b1, 1'b0, v3b,  v3);
        end
        step("stall_release",  1'b0, 1'b0, 1'b0, v3b,  v3b);
        step("flush_over_stall", 1'b0, 1'b1, 1'b1, vfl, bub);
        step("invalid_gating", 1'b0, 1'b0, 1'b0, vinv, einv);
        step("reset_mid_stall", 1'b1, 1'b1, 1'b0, all1, zero);
        step("load_all_ones",  1'b0, 1'b0, 1'b0, all1, all1);
        step("flush_b2b_1",    1'b0, 1'b0, 1'b1, all1, bub);
        step("flush_b2b_2",    1'b0, 1'b0, 1'b1, all1, bub);
        step("load_mixed",     1'b0, 1'b0, 1'b0, v14,  v14);
        step("stall_mixed",    1'b0, 1'b1, 1'b0, all1, v14);
        step("reset_mid_flush", 1'b1, 1'b0, 1'b1, all1, zero);

`ifdef ID_EX_PERF_EN
        step("perf_load",      1'b0, 1'b0, 1'b0, v3,   v3);
        for (int i = 0; i < 5; i++) begin
            step("perf_stall",  1'b0, 1'b1, 1'b0, v3b,  v3);
        end
        step("perf_flush",     1'b0, 1'b0, 1'b1, v3b,  bub);
        @(posedge clk);
        #2;
        check32("stall_count", StallCountE, 32'd5);
        check32("flush_count", FlushCountE, 32'd1);
        step("sat_load",       1'b0, 1'b0, 1'b0, v3,   v3);
        @(negedge clk);
        force dut.stall_cnt_r = 32'hFFFF_FFFF;
        step("sat_stall",      1'b0, 1'b1, 1'b0, v3,   v3);
        #1;
        release dut.stall_cnt_r;
        @(posedge clk);
        #2;
        check32("stall_count_sat", StallCountE, 32'hFFFF_FFFF);
`endif

        wait_cnt = 0;
        while (sbq.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        #2;
        if (sbq.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d entries left expected 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
